// File: rtl/seven_seg_scan_driver.sv
// Multiplexed 7-segment driver: scans NUM_DIGITS BCD digits onto one segment bus, one digit per SCAN_DIV clocks.
// Outputs are registered one cycle behind the scan index; there is no backpressure, and load is always accepted.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS     = 3,
  parameter int SCAN_DIV       = 1000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic                    lz_blank_en,
  input  logic                    blink_en,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] SEL_RST = NUM_DIGITS'(1);

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    case (v)
      4'd0:    bcd_to_seg = 7'b1111110;
      4'd1:    bcd_to_seg = 7'b0110000;
      4'd2:    bcd_to_seg = 7'b1101101;
      4'd3:    bcd_to_seg = 7'b1111001;
      4'd4:    bcd_to_seg = 7'b0110011;
      4'd5:    bcd_to_seg = 7'b1011011;
      4'd6:    bcd_to_seg = 7'b1011111;
      4'd7:    bcd_to_seg = 7'b1110000;
      4'd8:    bcd_to_seg = 7'b1111111;
      4'd9:    bcd_to_seg = 7'b1111011;
      default: bcd_to_seg = 7'b0000001;
    endcase
  endfunction

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d, act_q, act_d;
  logic                    shown_q, shown_d;
  logic                    phase_q, phase_d;
  logic [FW-1:0]           fcnt_q, fcnt_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    fd_q, fd_d;

  logic       slot_end, frame_end, blank, upper_zero, cur_dp, cur_lz;
  logic [3:0] cur_dig;

  always_comb begin
    slot_end  = (cnt_q == CW'(SCAN_DIV - 1));
    frame_end = slot_end && (idx_q == IW'(NUM_DIGITS - 1));
    cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
    idx_d     = idx_q;
    if (slot_end) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    pend_d    = load ? digits_in : pend_q;
    // Active digits only change at the frame boundary so a frame never mixes old and new values.
    act_d     = frame_end ? pend_q : act_q;
    shown_d   = shown_q | frame_end;
    fd_d      = frame_end;

    phase_d = phase_q;
    fcnt_d  = fcnt_q;
    if (!blink_en) begin
      phase_d = 1'b1;
      fcnt_d  = '0;
    end else if (frame_end) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  // Walk from the most significant digit down so upper_zero tracks "this and all higher digits are 0".
  always_comb begin
    cur_dig    = 4'd0;
    cur_dp     = 1'b0;
    cur_lz     = 1'b0;
    sel_d      = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (act_q[4*i +: 4] == 4'd0);
      if (idx_q == IW'(i)) begin
        cur_dig  = act_q[4*i +: 4];
        cur_dp   = dp_mask[i];
        cur_lz   = upper_zero && (i != 0);
        sel_d[i] = 1'b1;
      end
    end
    blank = !shown_q || (blink_en && !phase_q) || (lz_blank_en && cur_lz);
    seg_d = (blank ? 7'd0 : bcd_to_seg(cur_dig)) ^ {7{SEG_ACTIVE_LOW}};
    dp_d  = (cur_dp && !blank) ^ SEG_ACTIVE_LOW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= '0;
      act_q   <= '0;
      shown_q <= 1'b0;
      phase_q <= 1'b1;
      fcnt_q  <= '0;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
      sel_q   <= SEL_RST;
      fd_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      shown_q <= shown_d;
      phase_q <= phase_d;
      fcnt_q  <= fcnt_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      sel_q   <= sel_d;
      fd_q    <= fd_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign digit_sel  = sel_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: frame-level reference model feeds a slot scoreboard; a monitor checks every cycle.
module tb_seven_seg_scan_driver;

  localparam int ND = 3;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FRAME = ND * SD;

  typedef struct packed {
    logic [ND-1:0] sel;
    logic [6:0]    seg;
    logic          dp;
  } slot_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4*ND-1:0] digits_in = '0;
  logic          load = 1'b0;
  logic          lz_blank_en = 1'b0;
  logic          blink_en = 1'b0;
  logic [ND-1:0] dp_mask = '0;

  logic [6:0]    seg_out, seg_out_al;
  logic          dp_out, dp_out_al;
  logic [ND-1:0] digit_sel, digit_sel_al;
  logic          frame_done, frame_done_al;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .SEG_ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .load(load), .lz_blank_en(lz_blank_en),
    .blink_en(blink_en), .dp_mask(dp_mask), .seg_out(seg_out), .dp_out(dp_out),
    .digit_sel(digit_sel), .frame_done(frame_done));

  seven_seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .SEG_ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .load(load), .lz_blank_en(lz_blank_en),
    .blink_en(blink_en), .dp_mask(dp_mask), .seg_out(seg_out_al), .dp_out(dp_out_al),
    .digit_sel(digit_sel_al), .frame_done(frame_done_al));

  logic [6:0] dec_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011, 7'b0000001, 7'b0000001,
                               7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001};

  slot_t       exp_q[$];
  logic [11:0] dir_q[$] = '{12'h159, 12'h007, 12'h000, 12'h00C, 12'h888};
  logic [11:0] m_pend, m_act;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;
  int          tcnt;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sel"}, digit_sel, 1);
    check({tag, "_seg"}, seg_out, 0);
    check({tag, "_dp"}, dp_out, 0);
    check({tag, "_fd"}, frame_done, 0);
    check({tag, "_al_sel"}, digit_sel_al, 1);
    check({tag, "_al_seg"}, seg_out_al, 7'h7f);
    check({tag, "_al_dp"}, dp_out_al, 1);
    check({tag, "_al_fd"}, frame_done_al, 0);
  endtask

  // Expected content of digit d in frame f (frame 0 = the frame right after reset release).
  function automatic slot_t exp_slot(input int f, input int d, input logic [11:0] act,
                                     input bit lz, input bit bl, input logic [ND-1:0] dpm, input int s);
    slot_t r;
    bit    off, upper_zero;
    r.sel = ND'(1 << d);
    off = (f == 0) || (bl && (((f - s) / BF) % 2 == 1));
    upper_zero = 1'b1;
    for (int j = d; j < ND; j++) if (act[4*j +: 4] != 4'd0) upper_zero = 1'b0;
    if (lz && d != 0 && upper_zero) off = 1'b1;
    r.seg = off ? 7'd0 : dec_tab[act[4*d +: 4]];
    r.dp  = off ? 1'b0 : dpm[d];
    return r;
  endfunction

  function automatic logic [11:0] next_digits();
    logic [11:0] v;
    int          m;
    if (dir_q.size() > 0) return dir_q.pop_front();
    m = $urandom_range(0, 3);
    v = 12'($urandom);
    case (m)
      1: begin v[11:4] = 8'd0; v[3:0] = 4'($urandom_range(0, 9)); end
      2: v = 12'd0;
      3: v[11:8] = 4'd0;
      default: ;
    endcase
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= 0;
    else        tcnt <= tcnt + 1;
  end

  initial begin : monitor
    slot_t         cur;
    logic [ND-1:0] prev_sel;
    logic [6:0]    inv_seg;
    logic          inv_dp;
    int            run;
    cur = '0;
    prev_sel = '0;
    run = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n || tcnt < 1) begin
        run = 0;
        continue;
      end
      if (tcnt == 1 || digit_sel != prev_sel || run == SD) begin
        if (tcnt != 1) check("slot_len", run, SD);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard_underflow: got empty queue, expected a slot at %0t", $time);
          cur = '0;
        end else begin
          cur = exp_q.pop_front();
        end
        run = 0;
      end
      run++;
      prev_sel = digit_sel;
      inv_seg = ~cur.seg;
      inv_dp  = ~cur.dp;
      check("digit_sel", digit_sel, cur.sel);
      check("seg_out", seg_out, cur.seg);
      check("dp_out", dp_out, cur.dp);
      check("frame_done", frame_done, (tcnt % FRAME == 0));
      check("al_digit_sel", digit_sel_al, cur.sel);
      check("al_seg_out", seg_out_al, inv_seg);
      check("al_dp_out", dp_out_al, inv_dp);
      check("al_frame_done", frame_done_al, (tcnt % FRAME == 0));
    end
  end

  // Called with rst_n low; releases reset and drives nframes frames, or aborts mid-slot of digit 1 in frame abort_f.
  task automatic run_session(input int nframes, input int abort_f, input bit first);
    logic [11:0] late;
    bit          late_v, bl_prev, da, db;
    int          s, ca, cb;
    @(negedge clk);
    m_pend = '0;
    m_act = '0;
    s = 0;
    bl_prev = 1'b0;
    late = '0;
    exp_q.delete();
    for (int f = 0; f < nframes; f++) begin
      lz_blank_en = (first && f < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      blink_en = first ? (((f / 8) % 2) == 1) : (f >= 4 && f < 12);
      dp_mask = ND'($urandom);
      if (blink_en && !bl_prev) s = f;
      bl_prev = blink_en;
      for (int d = 0; d < ND; d++)
        exp_q.push_back(exp_slot(f, d, m_act, lz_blank_en, blink_en, dp_mask, s));
      if (f == 0) begin
        mon_en = 1'b1;
        rst_n = 1'b1;
      end
      ca = (first && f == 3) ? FRAME - 1 : $urandom_range(0, FRAME - 1);
      da = (first || f >= 2) && ((first && f == 3) || $urandom_range(0, 3) != 0);
      cb = $urandom_range(0, FRAME - 1);
      db = (first || f >= 2) && ($urandom_range(0, 3) == 0) && (cb != ca);
      late_v = 1'b0;
      for (int c = 0; c < FRAME; c++) begin
        if (f == abort_f && c == 6) begin
          mon_en = 1'b0;
          load = 1'b0;
          rst_n = 1'b0;
          #1;
          check_reset("abort");
          exp_q.delete();
          return;
        end
        load = 1'b0;
        if ((da && c == ca) || (db && c == cb)) begin
          digits_in = next_digits();
          load = 1'b1;
          if (c == FRAME - 1) begin
            late = digits_in;
            late_v = 1'b1;
          end else begin
            m_pend = digits_in;
          end
        end
        @(posedge clk);
        #1;
      end
      load = 1'b0;
      m_act = m_pend;
      if (late_v) m_pend = late;
    end
    mon_en = 1'b0;
    check("queue_drain", exp_q.size(), 0);
  endtask

  initial begin : stimulus
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    run_session(40, 30, 1'b1);
    repeat (2) @(posedge clk);
    run_session(16, -1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
